// File: rtl/companion_core_n_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : companion_pkg
//  Description : Shared types and elaboration-time helpers for the companion
//                core: menu/exec state encoding and counter width functions.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package companion_pkg;

    // Menu controller states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MENU = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    // Width of the menu index; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold the values 0..n-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/companion_core_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : companion_core_n_if
//  Description : Button/graphics side bundle of the companion core.
//                master : board/graphics side (drives buttons, exec_status)
//                slave  : companion core (drives stats, menu and exec status)
//  Signals     : menu_button, next_button, select_button, exec_status,
//                stats, selected, menu_open, exec, busy, timeout, low_mask
//  Revision    : 1.0 - initial release
// ============================================================================
interface companion_core_n_if
    import companion_pkg::*;
#(
    parameter int NUM_STATS = 4,
    parameter int STAT_W    = 32
);
    localparam int SEL_W = sel_width(NUM_STATS);

    logic                        menu_button;
    logic                        next_button;
    logic                        select_button;
    logic                        exec_status;
    logic [NUM_STATS*STAT_W-1:0] stats;
    logic [SEL_W-1:0]            selected;
    logic                        menu_open;
    logic                        exec;
    logic                        busy;
    logic                        timeout;
    logic [NUM_STATS-1:0]        low_mask;

    modport master (
        output menu_button, next_button, select_button, exec_status,
        input  stats, selected, menu_open, exec, busy, timeout, low_mask
    );

    modport slave (
        input  menu_button, next_button, select_button, exec_status,
        output stats, selected, menu_open, exec, busy, timeout, low_mask
    );

endinterface
`default_nettype wire

// File: rtl/companion_stat_bank.sv
`default_nettype none
// ============================================================================
//  Module      : companion_stat_bank
//  Description : NUM_STATS saturating stat counters with a shared decay
//                prescaler, boost/decay arbitration and a registered
//                low-threshold mask.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                boost_en_i      - apply BOOST to stat boost_idx_i this cycle
//                boost_idx_i     - index of the stat to boost
//                stats_o         - packed stats, stat i at [i*STAT_W +: STAT_W]
//                low_mask_o      - bit i set when stat i < LOW_THRESH (1 cycle lag)
//  Revision    : 1.0 - initial release
// ============================================================================
module companion_stat_bank
    import companion_pkg::*;
#(
    parameter int NUM_STATS    = 4,
    parameter int STAT_W       = 32,
    parameter int STAT_MAX     = 100,
    parameter int DECAY_CYCLES = 125_000_000,
    parameter int BOOST        = 20,
    parameter int LOW_THRESH   = 25,
    parameter int SEL_W        = 2
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        boost_en_i,
    input  wire logic [SEL_W-1:0]            boost_idx_i,
    output      logic [NUM_STATS*STAT_W-1:0] stats_o,
    output      logic [NUM_STATS-1:0]        low_mask_o
);

    localparam int PS_W = cnt_width(DECAY_CYCLES);

    localparam logic [PS_W-1:0]   c_PS_LAST   = PS_W'(DECAY_CYCLES - 1);
    localparam logic [PS_W-1:0]   c_PS_ONE    = PS_W'(1);
    localparam logic [STAT_W-1:0] c_MAX       = STAT_W'(STAT_MAX);
    localparam logic [STAT_W-1:0] c_ONE       = STAT_W'(1);
    localparam logic [STAT_W-1:0] c_ZERO      = '0;
    // One extra bit so stat + BOOST can never wrap before saturation.
    localparam logic [STAT_W:0]   c_BOOST_EXT = (STAT_W + 1)'(BOOST);
    localparam logic [STAT_W:0]   c_MAX_EXT   = (STAT_W + 1)'(STAT_MAX);
    localparam logic [STAT_W:0]   c_LOW_EXT   = (STAT_W + 1)'(LOW_THRESH);

    logic [PS_W-1:0] prescaler_q;
    logic            w_tick;

    assign w_tick = (prescaler_q == c_PS_LAST);

    // Free-running decay prescaler, independent of the menu state.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q <= '0;
        end else if (w_tick) begin
            prescaler_q <= '0;
        end else begin
            prescaler_q <= prescaler_q + c_PS_ONE;
        end
    end

    for (genvar i = 0; i < NUM_STATS; i++) begin : g_stat
        logic [STAT_W-1:0] stat_q;
        logic [STAT_W-1:0] stat_d;
        logic              low_q;
        logic [STAT_W:0]   w_sum;
        logic              w_boost_here;

        assign w_sum        = {1'b0, stat_q} + c_BOOST_EXT;
        assign w_boost_here = boost_en_i && (boost_idx_i == SEL_W'(i));

        // A boost on this stat wins over a coincident decay tick.
        always_comb begin
            stat_d = stat_q;
            if (w_boost_here) begin
                stat_d = (w_sum > c_MAX_EXT) ? c_MAX : w_sum[STAT_W-1:0];
            end else if (w_tick && (stat_q != c_ZERO)) begin
                stat_d = stat_q - c_ONE;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stat_q <= c_MAX;
                low_q  <= 1'b0;
            end else begin
                stat_q <= stat_d;
                low_q  <= ({1'b0, stat_q} < c_LOW_EXT);
            end
        end

        assign stats_o[i*STAT_W +: STAT_W] = stat_q;
        assign low_mask_o[i]               = low_q;
    end

endmodule
`default_nettype wire

// File: rtl/companion_core_n.sv
`default_nettype none
// ============================================================================
//  Module      : companion_core_n
//  Description : Companion menu controller: button edge detection, IDLE/MENU/
//                EXEC state machine with exec timeout, driving a stat bank.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                bus  - companion_core_n_if.slave (buttons, exec_status in;
//                       stats, selected, menu_open, exec, busy, timeout,
//                       low_mask out)
//  Revision    : 1.0 - initial release
// ============================================================================
module companion_core_n
    import companion_pkg::*;
#(
    parameter int NUM_STATS    = 4,
    parameter int STAT_W       = 32,
    parameter int STAT_MAX     = 100,
    parameter int DECAY_CYCLES = 125_000_000,
    parameter int BOOST        = 20,
    parameter int LOW_THRESH   = 25,
    parameter int EXEC_TIMEOUT = 250_000_000
) (
    input wire logic         clk,
    input wire logic         rst,
    companion_core_n_if.slave bus
);

    localparam int SEL_W = sel_width(NUM_STATS);
    localparam int TO_W  = cnt_width(EXEC_TIMEOUT);

    localparam logic [TO_W-1:0]  c_TO_LAST  = TO_W'(EXEC_TIMEOUT - 1);
    localparam logic [TO_W-1:0]  c_TO_ONE   = TO_W'(1);
    localparam logic [SEL_W-1:0] c_SEL_LAST = SEL_W'(NUM_STATS - 1);
    localparam logic [SEL_W-1:0] c_SEL_ONE  = SEL_W'(1);

    state_t           state_q;
    logic [SEL_W-1:0] selected_q;
    logic             menu_open_q;
    logic             busy_q;
    logic             exec_q;
    logic             timeout_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             menu_btn_q;
    logic             next_btn_q;
    logic             select_btn_q;

    logic             w_menu_pulse;
    logic             w_next_pulse;
    logic             w_select_pulse;
    logic             w_boost_en;

    // Rising edges relative to the previous sampled level.
    assign w_menu_pulse   = bus.menu_button   & ~menu_btn_q;
    assign w_next_pulse   = bus.next_button   & ~next_btn_q;
    assign w_select_pulse = bus.select_button & ~select_btn_q;

    // The boost lands on the same edge that enters EXEC, so the boosted value
    // is visible in the cycle where exec is high.
    assign w_boost_en = (state_q == ST_MENU) && w_select_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            selected_q   <= '0;
            menu_open_q  <= 1'b0;
            busy_q       <= 1'b0;
            exec_q       <= 1'b0;
            timeout_q    <= 1'b0;
            to_cnt_q     <= '0;
            menu_btn_q   <= 1'b0;
            next_btn_q   <= 1'b0;
            select_btn_q <= 1'b0;
        end else begin
            menu_btn_q   <= bus.menu_button;
            next_btn_q   <= bus.next_button;
            select_btn_q <= bus.select_button;
            exec_q       <= 1'b0;
            timeout_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (w_menu_pulse) begin
                        state_q     <= ST_MENU;
                        menu_open_q <= 1'b1;
                        selected_q  <= '0;
                    end
                end

                ST_MENU: begin
                    if (w_select_pulse) begin
                        state_q     <= ST_EXEC;
                        menu_open_q <= 1'b0;
                        busy_q      <= 1'b1;
                        exec_q      <= 1'b1;
                        to_cnt_q    <= '0;
                    end else if (w_menu_pulse) begin
                        state_q     <= ST_IDLE;
                        menu_open_q <= 1'b0;
                    end else if (w_next_pulse) begin
                        selected_q  <= (selected_q == c_SEL_LAST) ? '0
                                                                  : selected_q + c_SEL_ONE;
                    end
                end

                ST_EXEC: begin
                    if (bus.exec_status) begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                    end else if (to_cnt_q == c_TO_LAST) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + c_TO_ONE;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    menu_open_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    companion_stat_bank #(
        .NUM_STATS    (NUM_STATS),
        .STAT_W       (STAT_W),
        .STAT_MAX     (STAT_MAX),
        .DECAY_CYCLES (DECAY_CYCLES),
        .BOOST        (BOOST),
        .LOW_THRESH   (LOW_THRESH),
        .SEL_W        (SEL_W)
    ) u_stat_bank (
        .clk          (clk),
        .rst          (rst),
        .boost_en_i   (w_boost_en),
        .boost_idx_i  (selected_q),
        .stats_o      (bus.stats),
        .low_mask_o   (bus.low_mask)
    );

    assign bus.selected  = selected_q;
    assign bus.menu_open = menu_open_q;
    assign bus.busy      = busy_q;
    assign bus.exec      = exec_q;
    assign bus.timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_companion_core_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_companion_core_n
//  Description : Directed self-checking bench for companion_core_n with
//                NUM_STATS=4, STAT_W=8, DECAY_CYCLES=10, EXEC_TIMEOUT=50.
//                Edge numbers count rising edges since reset release.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_companion_core_n;

    localparam int c_BTN_MENU   = 0;
    localparam int c_BTN_NEXT   = 1;
    localparam int c_BTN_SELECT = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   edge_n;

    companion_core_n_if #(.NUM_STATS(4), .STAT_W(8)) bus ();

    companion_core_n #(
        .NUM_STATS    (4),
        .STAT_W       (8),
        .STAT_MAX     (100),
        .DECAY_CYCLES (10),
        .BOOST        (20),
        .LOW_THRESH   (25),
        .EXEC_TIMEOUT (50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic wait_to(input int n);
        while (edge_n < n) step();
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            c_BTN_MENU:   bus.menu_button   = v;
            c_BTN_NEXT:   bus.next_button   = v;
            default:      bus.select_button = v;
        endcase
    endtask

    // Press then release: the action happens on the first of the two edges.
    task automatic press(input int which);
        set_btn(which, 1'b1);
        step();
        set_btn(which, 1'b0);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        edge_n = 0;
    endtask

    function automatic logic [31:0] pack4(input logic [7:0] s3, input logic [7:0] s2,
                                          input logic [7:0] s1, input logic [7:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_sel [5];
        int seen;
        exp_sel = '{1, 2, 3, 0, 1};
        n_checks = 0;
        n_errors = 0;
        edge_n   = 0;
        bus.menu_button   = 1'b0;
        bus.next_button   = 1'b0;
        bus.select_button = 1'b0;
        bus.exec_status   = 1'b0;

        // ---------------- reset state and decay ----------------
        do_reset();
        check("rst_stats",    bus.stats, pack4(100, 100, 100, 100));
        check("rst_selected", bus.selected, 0);
        check("rst_menu",     bus.menu_open, 0);
        check("rst_busy",     bus.busy, 0);
        check("rst_exec",     bus.exec, 0);
        check("rst_timeout",  bus.timeout, 0);
        check("rst_low",      bus.low_mask, 0);

        wait_to(9);
        check("pre_tick",    bus.stats, pack4(100, 100, 100, 100));
        wait_to(10);
        check("first_tick",  bus.stats, pack4(99, 99, 99, 99));
        wait_to(751);
        check("at_thresh",   bus.stats, pack4(25, 25, 25, 25));
        check("low_at_25",   bus.low_mask, 4'b0000);
        wait_to(760);
        check("below_th",    bus.stats, pack4(24, 24, 24, 24));
        check("low_lag",     bus.low_mask, 4'b0000);
        wait_to(761);
        check("low_set",     bus.low_mask, 4'b1111);
        wait_to(1000);
        check("decay_zero",  bus.stats, 0);
        wait_to(1020);
        check("zero_held",   bus.stats, 0);
        check("low_zero",    bus.low_mask, 4'b1111);

        // ---------------- menu navigation and boost ----------------
        do_reset();
        press(c_BTN_MENU);
        check("menu_open",   bus.menu_open, 1);
        check("menu_sel0",   bus.selected, 0);
        for (int k = 0; k < 5; k++) begin
            press(c_BTN_NEXT);
            check($sformatf("next_%0d", k), bus.selected, exp_sel[k]);
        end
        wait_to(500);
        check("pre_sel_stats", bus.stats, pack4(50, 50, 50, 50));
        check("still_menu",  bus.menu_open, 1);
        bus.select_button = 1'b1;
        step();                                   // edge 501
        check("exec_pulse",  bus.exec, 1);
        check("exec_busy",   bus.busy, 1);
        check("exec_menu",   bus.menu_open, 0);
        check("boost_s1",    bus.stats, pack4(50, 50, 70, 50));
        bus.select_button = 1'b0;
        step();                                   // edge 502
        check("exec_one",    bus.exec, 0);
        check("busy_hold",   bus.busy, 1);
        bus.exec_status = 1'b1;
        step();                                   // edge 503
        bus.exec_status = 1'b0;
        check("done_busy",   bus.busy, 0);
        check("done_to",     bus.timeout, 0);

        // ---------------- saturation and boost vs. tick ----------------
        do_reset();
        wait_to(50);
        press(c_BTN_MENU);                        // edges 51,52
        press(c_BTN_NEXT);                        // 53,54
        press(c_BTN_NEXT);                        // 55,56
        bus.select_button = 1'b1;
        step();                                   // edge 57
        check("sat_boost",   bus.stats, pack4(95, 100, 95, 95));
        bus.select_button = 1'b0;
        step();                                   // 58
        bus.exec_status = 1'b1;
        step();                                   // 59
        bus.exec_status = 1'b0;
        check("sat_idle",    bus.busy, 0);
        wait_to(60);
        check("sat_decay",   bus.stats, pack4(94, 99, 94, 94));
        press(c_BTN_MENU);                        // 61,62
        press(c_BTN_NEXT);                        // 63,64
        press(c_BTN_NEXT);                        // 65,66
        check("sel_two",     bus.selected, 2);
        wait_to(69);
        bus.select_button = 1'b1;
        step();                                   // edge 70: boost and tick
        check("boost_tick",  bus.stats, pack4(93, 100, 93, 93));
        check("bt_exec",     bus.exec, 1);
        bus.select_button = 1'b0;
        step();                                   // 71

        // ---------------- buttons ignored in EXEC, timeout ----------------
        wait_to(80);
        press(c_BTN_NEXT);                        // 81,82
        press(c_BTN_SELECT);                      // 83,84
        press(c_BTN_MENU);                        // 85,86
        check("exec_sel_hold", bus.selected, 2);
        check("exec_no_boost", bus.stats, pack4(92, 99, 92, 92));
        check("exec_busy2",  bus.busy, 1);
        wait_to(119);
        check("to_busy_last", bus.busy, 1);
        check("to_not_yet",  bus.timeout, 0);
        step();                                   // 120
        check("to_pulse",    bus.timeout, 1);
        check("to_idle",     bus.busy, 0);
        check("to_no_exec",  bus.exec, 0);
        check("to_menu",     bus.menu_open, 0);
        step();                                   // 121
        check("to_one",      bus.timeout, 0);

        // ---------------- exec_status ends EXEC early ----------------
        press(c_BTN_MENU);                        // 122,123
        bus.select_button = 1'b1;
        step();                                   // 124
        bus.select_button = 1'b0;
        check("s0_boost",    bus.stats, pack4(88, 95, 88, 100));
        step();                                   // 125
        step();                                   // 126
        bus.exec_status = 1'b1;
        step();                                   // 127
        bus.exec_status = 1'b0;
        check("status_idle", bus.busy, 0);
        check("status_no_to", bus.timeout, 0);
        seen = 0;
        while (edge_n < 200) begin
            step();
            if (bus.timeout) seen++;
        end
        check("no_late_to",  seen, 0);

        // ---------------- held button, simultaneous pulses ----------------
        bus.menu_button = 1'b1;
        step();
        check("hold_open",   bus.menu_open, 1);
        repeat (19) step();
        check("hold_still",  bus.menu_open, 1);
        bus.menu_button = 1'b0;
        step();
        press(c_BTN_NEXT);
        check("hold_sel",    bus.selected, 1);
        bus.select_button = 1'b1;
        bus.menu_button   = 1'b1;
        step();
        check("both_busy",   bus.busy, 1);
        check("both_exec",   bus.exec, 1);
        check("both_menu",   bus.menu_open, 0);
        bus.select_button = 1'b0;
        bus.menu_button   = 1'b0;
        step();

        // ---------------- reset during EXEC ----------------
        check("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        step();
        check("mid_rst_busy",  bus.busy, 0);
        check("mid_rst_menu",  bus.menu_open, 0);
        check("mid_rst_stats", bus.stats, pack4(100, 100, 100, 100));
        check("mid_rst_sel",   bus.selected, 0);
        check("mid_rst_to",    bus.timeout, 0);
        rst = 1'b0;
        step();
        check("post_rst_to",   bus.timeout, 0);
        check("post_rst_busy", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/companion_core_n.md
Name: companion_core_n

Overview:
- Parametrised successor to the companion menu/status pair. One block holds NUM_STATS saturating stat counters with periodic decay.
- A button-driven menu (open, cycle, select) applies a boost to the chosen stat and then waits for the graphics animation handshake.
- Adds the following:
  - button rising-edge detection;
  - an exec timeout;
  - a per-stat low-threshold alert mask;
  - a busy indication.
- Sits between the board buttons and the graphics module.

Parameters:
- NUM_STATS, 4: number of stats and menu items (2..16); item i boosts stat i.
- STAT_W, 32: width of each stat counter.
- STAT_MAX, 100: reset value and saturation ceiling of every stat.
- DECAY_CYCLES, 125_000_000: clock cycles between decay ticks (>=1).
- BOOST, 20: amount added to the selected stat on execute.
- LOW_THRESH, 25: a stat strictly below this sets its low_mask bit.
- EXEC_TIMEOUT, 250_000_000: maximum cycles to wait for exec_status (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- menu_button  input  1  level; rising edge opens or closes the menu.
- next_button  input  1  level; rising edge advances the selection.
- select_button  input  1  level; rising edge executes the selected item.
- exec_status  input  1  graphics asserts 1 when the animation has finished.
- stats  output  NUM_STATS*STAT_W  packed stats; stat i is at bits [i*STAT_W +: STAT_W].
- selected  output  SEL_W  current menu index; SEL_W = max(1, $clog2(NUM_STATS)).
- menu_open  output  1  high in the MENU state.
- exec  output  1  one-cycle pulse on execute.
- busy  output  1  high in the EXEC state.
- timeout  output  1  one-cycle pulse when the exec wait times out.
- low_mask  output  NUM_STATS  bit i = (stat i < LOW_THRESH), registered.

Behaviour:
- Reset (synchronous, all registers):
  - state = IDLE;
  - stats = STAT_MAX;
  - selected = 0;
  - exec, timeout, busy, menu_open = 0;
  - low_mask = 0;
  - prescaler = 0;
  - timeout counter = 0;
  - edge-detector history = 0.
- Reset asserted mid-EXEC aborts to IDLE with no timeout pulse.
- Buttons: each button is registered once. pulse = btn & ~btn_q, valid on the cycle after the level rises. A held button gives exactly one pulse.
- IDLE:
  - menu pulse -> MENU, selected = 0.
  - next and select pulses are ignored.
- MENU: priority select > menu > next.
  - select pulse -> EXEC. exec = 1 for exactly the next cycle, and the boost is applied to stat[selected] on that same cycle.
  - menu pulse -> IDLE.
  - next pulse -> selected = (selected == NUM_STATS-1) ? 0 : selected+1.
- EXEC:
  - All button pulses are ignored; selected is held.
  - exec_status == 1 -> IDLE. This is checked from the first EXEC cycle onward; exec_status is ignored in other states.
  - Otherwise the counter increments. When it reaches EXEC_TIMEOUT-1 without exec_status: -> IDLE and timeout = 1 for one cycle.
  - The counter clears on entry to EXEC.
- menu_open = (state == MENU); busy = (state == EXEC); both registered with state.
- Decay:
  - The prescaler counts 0..DECAY_CYCLES-1 and wraps. A tick fires on the cycle it equals DECAY_CYCLES-1.
  - On a tick every stat decrements by 1, saturating at 0.
  - The prescaler runs in all states.
- Boost: stat = min(stat + BOOST, STAT_MAX). The addition is done at STAT_W+1 bits, so there is no wrap.
- Simultaneous boost and tick on the same stat: the boost is applied and the decay is skipped for that stat on that cycle. Other stats decay normally.
- low_mask is registered from the stat values; it lags the stats by one cycle.
- exec and timeout are never high in the same cycle.

Decomposition:
- Package companion_pkg holds:
  - the state enum (IDLE=0, MENU=1, EXEC=2) as a 2-bit typedef;
  - a localparam helper function for SEL_W.
- One sub-module: companion_stat_bank.
  - Owns the NUM_STATS counters, the decay prescaler, boost/decay arbitration, and low_mask.
  - Inputs: clk, rst, boost_en, boost_idx.
  - Outputs: stats, low_mask.
- The FSM, edge detection and timeout live in companion_core_n.

Test Plan:
All scenarios use NUM_STATS=4, STAT_W=8, STAT_MAX=100, DECAY_CYCLES=10, BOOST=20, LOW_THRESH=25, EXEC_TIMEOUT=50.
1. Reset, then 10 idle cycles -> all stats 99 after the first tick; 100 ticks -> all stats 0 and held at 0; low_mask = 4'b1111 once stats < 25.
2. Menu pulse, then next x5 -> selected goes 1,2,3,0,1. Then select, with stat1 at 50 -> exec high exactly 1 cycle; stat1 = 70; busy = 1; menu_open = 0.
3. Select at stat2 = 95 -> stat2 = 100 (saturated). Boost coincident with a tick -> boosted stat = 100 while the others decrement by 1.
4. In EXEC, hold exec_status = 0 -> after 50 cycles timeout pulses once and state = IDLE. Repeat with exec_status = 1 at cycle 3 -> IDLE, no timeout.
5. Hold menu_button high for 20 cycles -> a single open, no close. Pulse next/select in EXEC -> no change. Select and menu pulses in the same MENU cycle -> EXEC taken.
6. Assert rst during EXEC -> the next cycle shows state IDLE, stats = 100, selected = 0, no timeout pulse.
